// File: rtl/axi_traffic_gen.sv
// AXI manager traffic generator: randomised INCR bursts into a private address window,
// with a reference copy of every written word used to check each read beat.
package axi_pkg;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 64;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
      logic                      lock;
      logic [3:0]                cache;
      logic [2:0]                prot;
      logic [3:0]                qos;
   } axi_aw_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
      logic                      lock;
      logic [3:0]                cache;
      logic [2:0]                prot;
      logic [3:0]                qos;
   } axi_ar_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [AXI_STRB_WIDTH-1:0] strb;
      logic                      last;
   } axi_w_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
   } axi_b_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic                      last;
   } axi_r_t;
endpackage

module axi_traffic_gen
   import axi_pkg::*;
#(
   parameter int          TRANSACTION_NB = 1000,
   parameter int          MAX_BURST_LEN  = 8,
   parameter int          MEM_DEPTH      = 1024,
   parameter logic [63:0] SEED           = 64'hdeadbeefdeadbeef
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_index,
   input  logic        start,
   output logic        done,
   output logic [15:0] error_count,
   output axi_aw_t     o_axi_m_aw,
   input  logic        i_axi_m_awready,
   output logic        o_axi_m_awvalid,
   output axi_w_t      o_axi_m_w,
   input  logic        i_axi_m_wready,
   output logic        o_axi_m_wvalid,
   input  axi_b_t      i_axi_m_b,
   output logic        o_axi_m_bready,
   input  logic        i_axi_m_bvalid,
   output axi_ar_t     o_axi_m_ar,
   input  logic        i_axi_m_arready,
   output logic        o_axi_m_arvalid,
   input  axi_r_t      i_axi_m_r,
   output logic        o_axi_m_rready,
   input  logic        i_axi_m_rvalid
);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int OFF    = $clog2(AXI_DATA_WIDTH / 8);
   localparam int BEAT_W = 9;
   localparam int REP    = AXI_DATA_WIDTH / 64;

   typedef enum logic [3:0] {S_IDLE, S_GEN, S_WAIT, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

   state_t              r_state, w_next;
   logic [63:0]         r_x;
   logic                r_rwb;
   logic [3:0]          r_wait;
   logic [BEAT_W-1:0]   r_beats, r_k;
   logic [IDX_W-1:0]    r_idx;
   logic [31:0]         r_cnt;
   logic [15:0]         r_err;
   logic [MEM_DEPTH-1:0] r_vbits;
   logic [63:0]         r_ref [MEM_DEPTH];

   logic [63:0]         w_x_step, w_addr_full;
   logic [31:0]         w_mod;
   logic [BEAT_W-1:0]   w_beats_gen;
   logic [IDX_W-1:0]    w_idx_raw, w_idx_gen, w_ptr;
   logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic                w_final_beat, w_last_txn, w_r_exit;
   logic                w_data_bad, w_resp_bad, w_last_bad;
   logic [1:0]          w_r_errs;
   logic                w_unused;

   function automatic logic [63:0] xs64star(input logic [63:0] x);
      logic [63:0] v;
      v = x ^ (x >> 12);
      v = v ^ (v << 25);
      v = v ^ (v >> 27);
      return v * 64'h2545F4914F6CDD1D;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + 17'(b);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Burst parameters drawn from the freshly stepped PRNG word; bursts are clamped, never wrapped.
   assign w_x_step    = xs64star(r_x);
   assign w_mod       = 32'(w_x_step[15:10]) % 32'(MAX_BURST_LEN);
   assign w_beats_gen = BEAT_W'(w_mod + 32'd1);
   assign w_idx_raw   = w_x_step[16 +: IDX_W];
   assign w_idx_gen   = (32'(w_idx_raw) + 32'(w_beats_gen) > 32'(MEM_DEPTH))
                        ? IDX_W'(32'(MEM_DEPTH) - 32'(w_beats_gen)) : w_idx_raw;

   assign w_ptr        = IDX_W'(32'(r_idx) + 32'(r_k));
   assign w_addr_full  = (64'(cpu_index) << (IDX_W + OFF)) | (64'(r_idx) << OFF);
   assign w_final_beat = (r_k == r_beats - BEAT_W'(1));
   assign w_last_txn   = (r_cnt + 32'd1 == 32'(TRANSACTION_NB));

   assign w_aw_hs = o_axi_m_awvalid && i_axi_m_awready;
   assign w_w_hs  = o_axi_m_wvalid  && i_axi_m_wready;
   assign w_b_hs  = o_axi_m_bready  && i_axi_m_bvalid;
   assign w_ar_hs = o_axi_m_arvalid && i_axi_m_arready;
   assign w_r_hs  = o_axi_m_rready  && i_axi_m_rvalid;

   assign w_data_bad = r_vbits[w_ptr] && (i_axi_m_r.data != {REP{r_ref[w_ptr]}});
   assign w_resp_bad = (i_axi_m_r.resp != AXI_RESP_OKAY);
   assign w_last_bad = (i_axi_m_r.last != w_final_beat);
   assign w_r_errs   = 2'(w_data_bad) + 2'(w_resp_bad) + 2'(w_last_bad);
   assign w_r_exit   = i_axi_m_r.last || w_final_beat;

   assign w_unused = ^{i_axi_m_b.id, i_axi_m_r.id, w_addr_full[63:AXI_ADDR_WIDTH]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_GEN;
         S_GEN:   w_next = S_WAIT;
         S_WAIT:  if (r_wait == 4'd0) w_next = r_rwb ? S_AR : S_AW;
         S_AR:    if (w_ar_hs) w_next = S_R;
         S_R:     if (w_r_hs && w_r_exit) w_next = w_last_txn ? S_DONE : S_GEN;
         S_AW:    if (w_aw_hs) w_next = S_W;
         S_W:     if (w_w_hs && w_final_beat) w_next = S_B;
         S_B:     if (w_b_hs) w_next = w_last_txn ? S_DONE : S_GEN;
         S_DONE:  w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Payloads are forced to zero whenever their valid is low.
   always_comb begin
      o_axi_m_aw      = '0;
      o_axi_m_ar      = '0;
      o_axi_m_w       = '0;
      o_axi_m_awvalid = (r_state == S_AW);
      o_axi_m_arvalid = (r_state == S_AR);
      o_axi_m_wvalid  = (r_state == S_W);
      o_axi_m_rready  = (r_state == S_R);
      o_axi_m_bready  = (r_state == S_B);
      done            = (r_state == S_DONE);
      error_count     = r_err;
      if (r_state == S_AW) begin
         o_axi_m_aw.id    = cpu_index[AXI_ID_WIDTH-1:0];
         o_axi_m_aw.addr  = w_addr_full[AXI_ADDR_WIDTH-1:0];
         o_axi_m_aw.len   = 8'(r_beats - BEAT_W'(1));
         o_axi_m_aw.size  = 3'(OFF);
         o_axi_m_aw.burst = AXI_BURST_INCR;
      end
      if (r_state == S_AR) begin
         o_axi_m_ar.id    = cpu_index[AXI_ID_WIDTH-1:0];
         o_axi_m_ar.addr  = w_addr_full[AXI_ADDR_WIDTH-1:0];
         o_axi_m_ar.len   = 8'(r_beats - BEAT_W'(1));
         o_axi_m_ar.size  = 3'(OFF);
         o_axi_m_ar.burst = AXI_BURST_INCR;
      end
      if (r_state == S_W) begin
         o_axi_m_w.id   = cpu_index[AXI_ID_WIDTH-1:0];
         o_axi_m_w.data = {REP{r_x ^ 64'(r_k)}};
         o_axi_m_w.strb = '1;
         o_axi_m_w.last = w_final_beat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x     <= '0;
         r_rwb   <= 1'b0;
         r_wait  <= '0;
         r_beats <= '0;
         r_idx   <= '0;
         r_k     <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
         r_vbits <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_x   <= SEED + 64'(cpu_index);
               r_cnt <= '0;
            end
            S_GEN: begin
               r_x     <= w_x_step;
               r_rwb   <= w_x_step[4];
               r_wait  <= w_x_step[3:0];
               r_beats <= w_beats_gen;
               r_idx   <= w_idx_gen;
               r_k     <= '0;
            end
            S_WAIT: if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
            S_W: if (w_w_hs) begin
               r_vbits[w_ptr] <= 1'b1;
               if (!w_final_beat) r_k <= r_k + BEAT_W'(1);
            end
            S_R: if (w_r_hs) begin
               r_err <= sat_add(r_err, w_r_errs);
               if (w_r_exit) r_cnt <= r_cnt + 32'd1;
               else          r_k   <= r_k + BEAT_W'(1);
            end
            S_B: if (w_b_hs) begin
               r_err <= sat_add(r_err, 2'(i_axi_m_b.resp != AXI_RESP_OKAY));
               r_cnt <= r_cnt + 32'd1;
            end
            default: ;
         endcase
      end
   end

   // Reference data is deliberately left unreset; the valid bits gate every comparison.
   always_ff @(posedge clk) begin
      if (r_state == S_W && w_w_hs) r_ref[w_ptr] <= r_x ^ 64'(r_k);
   end
endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen: a reactive subordinate memory plus fault-injection
// knobs (read corruption, SLVERR, ready stalls) and a mid-burst asynchronous reset.
module tb_axi_traffic_gen;
   import axi_pkg::*;

   localparam int          TXN   = 200;
   localparam int          MAXB  = 8;
   localparam int          DEPTH = 64;
   localparam int          IDXW  = 6;
   localparam int          OFFB  = 3;
   localparam logic [63:0] SEED  = 64'hdeadbeefdeadbeef;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_index = 32'd1;
   logic        start = 1'b0;
   logic        done;
   logic [15:0] error_count;
   axi_aw_t     o_axi_m_aw;
   logic        i_axi_m_awready, o_axi_m_awvalid;
   axi_w_t      o_axi_m_w;
   logic        i_axi_m_wready, o_axi_m_wvalid;
   axi_b_t      i_axi_m_b;
   logic        o_axi_m_bready, i_axi_m_bvalid;
   axi_ar_t     o_axi_m_ar;
   logic        i_axi_m_arready, o_axi_m_arvalid;
   axi_r_t      i_axi_m_r;
   logic        o_axi_m_rready, i_axi_m_rvalid;

   axi_traffic_gen #(.TRANSACTION_NB(TXN), .MAX_BURST_LEN(MAXB), .MEM_DEPTH(DEPTH), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .cpu_index(cpu_index), .start(start), .done(done), .error_count(error_count),
      .o_axi_m_aw(o_axi_m_aw), .i_axi_m_awready(i_axi_m_awready), .o_axi_m_awvalid(o_axi_m_awvalid),
      .o_axi_m_w(o_axi_m_w), .i_axi_m_wready(i_axi_m_wready), .o_axi_m_wvalid(o_axi_m_wvalid),
      .i_axi_m_b(i_axi_m_b), .o_axi_m_bready(o_axi_m_bready), .i_axi_m_bvalid(i_axi_m_bvalid),
      .o_axi_m_ar(o_axi_m_ar), .i_axi_m_arready(i_axi_m_arready), .o_axi_m_arvalid(o_axi_m_arvalid),
      .i_axi_m_r(i_axi_m_r), .o_axi_m_rready(o_axi_m_rready), .i_axi_m_rvalid(i_axi_m_rvalid));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Knobs written only by the stimulus process.
   bit corrupt_arm = 1'b0, slverr_arm = 1'b0;
   int stall_req = 0;

   // Subordinate state, written only by the responder.
   axi_aw_t     aw_q, s_aw, aw_hold;
   axi_ar_t     ar_q, s_ar, ar_hold;
   axi_w_t      s_w, w_hold;
   logic        p_aw, p_w, p_b, p_ar, p_r;
   int          wbeat, rbeat, aw_hs, ar_hs, b_hs, w_beats, wexp;
   int          dead_reads, window_bad, stall_bad, stalled_cycles;
   int          aw_stall, w_stall, ar_stall;
   bit          aw_in, w_in, ar_in, b_pend, r_act, corrupt_used, slverr_used, first_cap;
   logic [31:0] first_addr;
   logic [7:0]  first_len;
   logic        first_rd;
   logic [63:0] smem [DEPTH];
   bit          swr  [DEPTH];

   function automatic logic [63:0] prng_step(input logic [63:0] x);
      logic [63:0] v;
      v = x ^ (x >> 12);
      v = v ^ (v << 25);
      v = v ^ (v >> 27);
      return v * 64'h2545F4914F6CDD1D;
   endfunction

   function automatic bit in_window(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] cpu);
      return ((addr >> (IDXW + OFFB)) == cpu) && (addr[OFFB-1:0] == '0)
             && (int'(addr[IDXW+OFFB-1:OFFB]) + int'(len) + 1 <= DEPTH);
   endfunction

   task automatic model_first(input logic [31:0] cpu, output logic [31:0] addr,
                              output logic [7:0] len, output logic rd);
      logic [63:0] x;
      int beats, idx;
      x = prng_step(SEED + 64'(cpu));
      rd = x[4];
      beats = int'(x[15:10]) % MAXB + 1;
      idx = int'(x[21:16]);
      if (idx + beats > DEPTH) idx = DEPTH - beats;
      addr = (cpu << (IDXW + OFFB)) | (32'(idx) << OFFB);
      len = 8'(beats - 1);
   endtask

   always @(negedge clk) begin
      int word;
      if (rst) begin
         i_axi_m_awready = 0; i_axi_m_wready = 0; i_axi_m_arready = 0;
         i_axi_m_bvalid = 0; i_axi_m_rvalid = 0; i_axi_m_b = '0; i_axi_m_r = '0;
         p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
         aw_q = '0; ar_q = '0; s_aw = '0; s_ar = '0; s_w = '0;
         wbeat = 0; rbeat = 0; aw_hs = 0; ar_hs = 0; b_hs = 0; w_beats = 0; wexp = 0;
         dead_reads = 0; window_bad = 0; stall_bad = 0; stalled_cycles = 0;
         aw_stall = stall_req; w_stall = stall_req; ar_stall = stall_req;
         aw_in = 0; w_in = 0; ar_in = 0; b_pend = 0; r_act = 0;
         corrupt_used = 0; slverr_used = 0; first_cap = 0;
         for (int i = 0; i < DEPTH; i++) swr[i] = 0;
      end else begin
         // Retire the handshakes that fired on the posedge just passed.
         if (p_aw) begin
            aw_q = s_aw; wbeat = 0; aw_hs++; wexp += int'(s_aw.len) + 1;
            if (!in_window(s_aw.addr, s_aw.len, cpu_index)) window_bad++;
            if (!first_cap) begin first_cap = 1; first_addr = s_aw.addr; first_len = s_aw.len; first_rd = 0; end
         end
         if (p_w) begin
            word = (int'(aw_q.addr[IDXW+OFFB-1:OFFB]) + wbeat) % DEPTH;
            smem[word] = s_w.data[63:0]; swr[word] = 1;
            if (s_w.last) b_pend = 1;
            wbeat++; w_beats++;
         end
         if (p_b) begin i_axi_m_bvalid = 0; b_hs++; end
         if (p_ar) begin
            ar_q = s_ar; rbeat = 0; r_act = 1; ar_hs++;
            if (!in_window(s_ar.addr, s_ar.len, cpu_index)) window_bad++;
            if (!first_cap) begin first_cap = 1; first_addr = s_ar.addr; first_len = s_ar.len; first_rd = 1; end
         end
         if (p_r) begin
            if (i_axi_m_r.last) r_act = 0;
            rbeat++;
         end
         // Address/data ready with optional one-off stalls and payload-stability watch.
         if (aw_in && !(o_axi_m_awvalid && o_axi_m_aw === aw_hold)) stall_bad++;
         if (o_axi_m_awvalid && aw_stall > 0) begin
            if (!aw_in) begin aw_hold = o_axi_m_aw; aw_in = 1; end
            i_axi_m_awready = 0; aw_stall--; stalled_cycles++;
         end else begin aw_in = 0; i_axi_m_awready = o_axi_m_awvalid; end
         if (ar_in && !(o_axi_m_arvalid && o_axi_m_ar === ar_hold)) stall_bad++;
         if (o_axi_m_arvalid && ar_stall > 0) begin
            if (!ar_in) begin ar_hold = o_axi_m_ar; ar_in = 1; end
            i_axi_m_arready = 0; ar_stall--; stalled_cycles++;
         end else begin ar_in = 0; i_axi_m_arready = o_axi_m_arvalid; end
         if (w_in && !(o_axi_m_wvalid && o_axi_m_w === w_hold)) stall_bad++;
         if (o_axi_m_wvalid && w_stall > 0) begin
            if (!w_in) begin w_hold = o_axi_m_w; w_in = 1; end
            i_axi_m_wready = 0; w_stall--; stalled_cycles++;
         end else begin w_in = 0; i_axi_m_wready = o_axi_m_wvalid; end
         if (b_pend && !i_axi_m_bvalid) begin
            i_axi_m_bvalid = 1; i_axi_m_b.id = aw_q.id; i_axi_m_b.resp = AXI_RESP_OKAY;
            if (slverr_arm && !slverr_used) begin i_axi_m_b.resp = AXI_RESP_SLVERR; slverr_used = 1; end
            b_pend = 0;
         end
         if (r_act) begin
            word = (int'(ar_q.addr[IDXW+OFFB-1:OFFB]) + rbeat) % DEPTH;
            i_axi_m_rvalid = 1; i_axi_m_r.id = ar_q.id; i_axi_m_r.resp = AXI_RESP_OKAY;
            i_axi_m_r.last = (rbeat == int'(ar_q.len));
            if (swr[word]) i_axi_m_r.data = smem[word];
            else begin i_axi_m_r.data = 64'hDEAD; dead_reads++; end
            if (corrupt_arm && !corrupt_used && swr[word]) begin
               i_axi_m_r.data[0] = ~i_axi_m_r.data[0]; corrupt_used = 1;
            end
         end else begin i_axi_m_rvalid = 0; i_axi_m_r = '0; end
         s_aw = o_axi_m_aw; s_ar = o_axi_m_ar; s_w = o_axi_m_w;
         p_aw = o_axi_m_awvalid && i_axi_m_awready;
         p_w  = o_axi_m_wvalid  && i_axi_m_wready;
         p_ar = o_axi_m_arvalid && i_axi_m_arready;
         p_b  = i_axi_m_bvalid  && o_axi_m_bready;
         p_r  = i_axi_m_rvalid  && o_axi_m_rready;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic run_to_done();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      for (int c = 0; c < 20000 && done !== 1'b1; c++) @(posedge clk);
      #1;
   endtask

   task automatic check_run(input string tag);
      check({tag, "_done"}, done, 1);
      check({tag, "_window"}, window_bad, 0);
      check({tag, "_txn_total"}, aw_hs + ar_hs, TXN);
      check({tag, "_b_per_aw"}, b_hs, aw_hs);
      check({tag, "_w_beats"}, w_beats, wexp);
   endtask

   initial begin
      logic [31:0] m_addr, saved_addr;
      logic [7:0]  m_len, saved_len;
      logic        m_rd;
      int          total;
      bit          found;

      // Run 1: clean memory, reset values, first transaction against the PRNG model.
      cpu_index = 32'd1;
      do_reset();
      #1;
      check("rst_awvalid", o_axi_m_awvalid, 0);
      check("rst_wvalid", o_axi_m_wvalid, 0);
      check("rst_arvalid", o_axi_m_arvalid, 0);
      check("rst_rready", o_axi_m_rready, 0);
      check("rst_bready", o_axi_m_bready, 0);
      check("rst_done", done, 0);
      check("rst_error_count", error_count, 0);
      check("rst_aw_zero", o_axi_m_aw === '0, 1);
      check("rst_w_zero", o_axi_m_w === '0, 1);
      check("rst_ar_zero", o_axi_m_ar === '0, 1);
      run_to_done();
      model_first(cpu_index, m_addr, m_len, m_rd);
      check("run1_first_addr", first_addr, m_addr);
      check("run1_first_len", first_len, m_len);
      check("run1_first_dir", first_rd, m_rd);
      check_run("run1");
      check("run1_errors", error_count, 0);
      check("run1_dead_reads_seen", dead_reads != 0, 1);
      total = aw_hs + ar_hs;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("done_sticky", done, 1);
      check("start_ignored", aw_hs + ar_hs, total);

      // Run 2: one read beat of a written word has bit 0 flipped.
      cpu_index = 32'd2;
      corrupt_arm = 1'b1;
      do_reset();
      run_to_done();
      check_run("run2");
      check("corrupt_injected", corrupt_used, 1);
      check("corrupt_errors", error_count, 1);
      corrupt_arm = 1'b0;

      // Run 3: one SLVERR write response.
      cpu_index = 32'd3;
      slverr_arm = 1'b1;
      do_reset();
      run_to_done();
      check_run("run3");
      check("slverr_injected", slverr_used, 1);
      check("slverr_errors", error_count, 1);
      slverr_arm = 1'b0;

      // Run 4: first AR, AW and W each see ready held low for 5 cycles.
      cpu_index = 32'd4;
      stall_req = 5;
      do_reset();
      run_to_done();
      check_run("run4");
      check("stall_errors", error_count, 0);
      check("stall_payload_held", stall_bad, 0);
      check("stall_cycles", stalled_cycles, 15);
      stall_req = 0;

      // Run 5: asynchronous reset on beat 2 of a write burst, then rerun the same seed.
      cpu_index = 32'd5;
      do_reset();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      for (int c = 0; c < 3000 && !first_cap; c++) @(posedge clk);
      saved_addr = first_addr;
      saved_len = first_len;
      found = 1'b0;
      for (int c = 0; c < 20000 && !found; c++) begin
         @(negedge clk); #1;
         if (o_axi_m_wvalid && wbeat == 2 && aw_q.len >= 8'd2) found = 1'b1;
      end
      check("midburst_reached", found, 1);
      rst = 1'b1;
      #1;
      check("async_wvalid", o_axi_m_wvalid, 0);
      check("async_w_zero", o_axi_m_w === '0, 1);
      check("async_awvalid", o_axi_m_awvalid, 0);
      check("async_bready", o_axi_m_bready, 0);
      check("async_done", done, 0);
      check("async_error_count", error_count, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      for (int c = 0; c < 3000 && !first_cap; c++) @(posedge clk);
      #1;
      model_first(cpu_index, m_addr, m_len, m_rd);
      check("rerun_addr_repeat", first_addr, saved_addr);
      check("rerun_len_repeat", first_len, saved_len);
      check("rerun_addr_model", first_addr, m_addr);
      check("rerun_len_model", first_len, m_len);
      for (int c = 0; c < 20000 && done !== 1'b1; c++) @(posedge clk);
      #1;
      check_run("run5");
      check("run5_errors", error_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
